rom_result_collector: RTL
=========================

# rom_result_collector

Downstream stage of the FIFO-to-ROM lookup stage. It consumes the `{tag[3:0], rom_data[31:0]}` result pulses that stage produces and files each word into a 16-slot bank indexed by tag. Once the expected number of distinct tags has arrived, it streams the collected words out in ascending tag order over a valid/ready interface, then pulses `done`.

## Interface
Parameters:
- `NUM_SLOTS`, 16, slot count; fixed by the 4-bit tag and not overridable.
- `DATA_W`, 32, ROM word width.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a collection; sampled only in IDLE.
- `num_expected`  in  5  distinct tags to collect; latched on `start`.
- `result_valid`  in  1  one-cycle pulse from the upstream lookup stage.
- `result`  in  36  `[35:32]` tag, `[31:0]` ROM data.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  downstream accepts the word.
- `out_tag`  out  4  tag of the current output word.
- `out_data`  out  32  data of the current output word.
- `out_last`  out  1  current word is the final one of the collection.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last output handshake.
- `dup_err`  out  1  sticky; a repeated tag arrived. Cleared on `start` or `rst`.

## Operation
- **Internal state**
  - Bank `slot[0..15]` of 32-bit words.
  - 16-bit `filled` mask.
  - 16-bit `pending` mask.
  - 5-bit `count`.
  - 5-bit latched target `N`.
- **IDLE**
  - On `start`: `N <= min(num_expected, 16)`, and `filled`, `pending`, `count`, `dup_err` all clear.
  - If `N == 0`, go to DONE. Otherwise go to COLLECT.
- **COLLECT**
  - On `result_valid` with `filled[tag] == 0`: `slot[tag] <= data`, set `filled[tag]` and `pending[tag]`, `count <= count + 1`.
  - On `result_valid` with `filled[tag] == 1`: discard the data (first arrival wins) and set `dup_err`. `count` is unchanged.
  - When the accepted word makes `count == N`, go to OUTPUT on the same edge.
- **OUTPUT**
  - `out_tag` is the lowest set bit of `pending`, found by a priority encoder.
  - `out_data = slot[out_tag]`.
  - `out_last` is high when exactly one bit of `pending` is set.
  - On `out_valid && out_ready`, clear that bit of `pending`.
  - When the cleared bit was the last one, go to DONE.
- **DONE**: `done = 1` for exactly one cycle, then IDLE.
- **Ignored inputs**
  - `result_valid` outside COLLECT, including in the `start` cycle.
  - `start` outside IDLE.
  - `out_ready` while `out_valid` is 0.
- **Output path**
  - `out_valid = (state == OUTPUT)`.
  - `out_*` are decoded only from registers; there is no combinational path from any input to any output.

## Timing
- **Reset**
  - Every output resets to 0: `out_valid`, `out_tag`, `out_data`, `out_last`, `busy`, `done`, `dup_err`.
  - State returns to IDLE and all masks and the bank clear.
  - Reset mid-collection or mid-output abandons the collection; no further `out_valid`.
- **Start**: `start` at edge t → `busy` = 1 from cycle t+1.
- **Collection**
  - Accepts one result per cycle; back-to-back `result_valid` is legal.
  - Result completing `N` at edge t → `out_valid` = 1 in cycle t+1.
- **Output**
  - With `out_ready` held high, one word per cycle; N words take N cycles.
  - `out_tag` and `out_data` stay stable while `out_valid && !out_ready`.
- **Completion**
  - Last handshake at edge t → `done` = 1 in cycle t+1, with `out_valid` = 0 and `busy` = 1.
  - `busy` = 0 from t+2.
  - `N == 0`: `start` at t → `done` in cycle t+1, with no output words.
- **Arithmetic**: `count` saturates at `N` and cannot wrap, because COLLECT exits on equality.

## Test plan
- **Basic collection**
  - Stimulus: `start`, N=3; results tag 5/0xA5A5A5A5, tag 1/0x11111111, tag 9/0x99999999; `out_ready` held high.
  - Response: outputs in order tag 1, tag 5, tag 9, one per cycle; `out_last` only on tag 9; `done` one cycle later.
- **Duplicate tag**
  - Stimulus: N=2; tag 3/0x1, then tag 3/0x2, then tag 4/0x3.
  - Response: `dup_err` = 1 after the second word; outputs tag 3/0x00000001, tag 4/0x00000003.
- **Backpressure**
  - Stimulus: N=2; `out_ready` low for 5 cycles, then high.
  - Response: tag and data held stable throughout; no word lost or repeated.
- **Boundary values of `num_expected`**
  - N=0: `done` the cycle after `start`; `out_valid` never asserted.
  - N=20 with all 16 tags sent: clamped to 16; tags 0..15 output in order.
- **Reset mid-output**
  - Stimulus: N=4; assert `rst` after 2 handshakes.
  - Response: all outputs 0 the next cycle; a new `start` with N=1 then works normally.
- **Ignored inputs**
  - `result_valid` in IDLE or OUTPUT: no effect on `count` or the bank.
  - `start` in COLLECT: `N` unchanged.

Source files
------------

// File: rtl/rom_result_collector_if.sv
// Output stream of the ROM result collector: one collected word per valid/ready handshake.
interface rom_result_collector_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4
);
    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_tag,
        output out_data,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_tag,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/rom_result_collector.sv
// Files tagged ROM lookup results into a 16-slot bank, then streams them out in ascending tag order.
module rom_result_collector (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4:0]              num_expected,
    input  logic                    result_valid,
    input  logic [35:0]             result,
    rom_result_collector_if.master  out_bus,
    output logic                    busy,
    output logic                    done,
    output logic                    dup_err
);
    localparam int unsigned NUM_SLOTS = 16;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT, DONE} state_t;

    state_t                 state;
    logic [DATA_W-1:0]      slot [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   filled;
    logic [NUM_SLOTS-1:0]   pending;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       n_target;

    logic [TAG_W-1:0]       in_tag;
    logic [DATA_W-1:0]      in_data;
    logic                   accept;
    logic                   dup;
    logic                   handshake;
    logic [CNT_W-1:0]       count_inc;
    logic [CNT_W-1:0]       n_clamp;
    logic [NUM_SLOTS-1:0]   pending_nxt;
    logic [TAG_W-1:0]       out_tag_nxt;
    logic [DATA_W-1:0]      out_data_nxt;
    logic                   out_last_nxt;

    function automatic logic [TAG_W-1:0] lowest_idx(input logic [NUM_SLOTS-1:0] m);
        logic [TAG_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (m[i]) idx = TAG_W'(i);
        end
        return idx;
    endfunction

    // Next-cycle pending mask and the output word it selects; bypasses a same-edge slot write.
    always_comb begin
        in_tag       = result[35:32];
        in_data      = result[31:0];
        accept       = (state == COLLECT) && result_valid && !filled[in_tag];
        dup          = (state == COLLECT) && result_valid &&  filled[in_tag];
        handshake    = (state == OUTPUT) && out_bus.out_ready;
        count_inc    = count + CNT_W'(1);
        n_clamp      = (num_expected > CNT_W'(NUM_SLOTS)) ? CNT_W'(NUM_SLOTS) : num_expected;
        pending_nxt  = pending;
        if (accept)    pending_nxt[in_tag]          = 1'b1;
        if (handshake) pending_nxt[out_bus.out_tag] = 1'b0;
        out_tag_nxt  = lowest_idx(pending_nxt);
        out_data_nxt = (accept && (in_tag == out_tag_nxt)) ? in_data : slot[out_tag_nxt];
        out_last_nxt = (pending_nxt != '0) &&
                       ((pending_nxt & (pending_nxt - NUM_SLOTS'(1))) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            filled            <= '0;
            pending           <= '0;
            count             <= '0;
            n_target          <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            dup_err           <= 1'b0;
            out_bus.out_valid <= 1'b0;
            out_bus.out_tag   <= '0;
            out_bus.out_data  <= '0;
            out_bus.out_last  <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) slot[i] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        n_target <= n_clamp;
                        filled   <= '0;
                        pending  <= '0;
                        count    <= '0;
                        dup_err  <= 1'b0;
                        busy     <= 1'b1;
                        if (n_clamp == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (dup) dup_err <= 1'b1;
                    if (accept) begin
                        slot[in_tag]     <= in_data;
                        filled[in_tag]   <= 1'b1;
                        pending          <= pending_nxt;
                        count            <= count_inc;
                        out_bus.out_tag  <= out_tag_nxt;
                        out_bus.out_data <= out_data_nxt;
                        out_bus.out_last <= out_last_nxt;
                        if (count_inc == n_target) begin
                            state             <= OUTPUT;
                            out_bus.out_valid <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (handshake) begin
                        pending          <= pending_nxt;
                        out_bus.out_tag  <= out_tag_nxt;
                        out_bus.out_data <= out_data_nxt;
                        out_bus.out_last <= out_last_nxt;
                        if (pending_nxt == '0) begin
                            state             <= DONE;
                            out_bus.out_valid <= 1'b0;
                            done              <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
